// File: rtl/gyro_pkg.sv
// Shared types and arithmetic helpers for the gyro integration path.
package gyro_pkg;

  typedef enum logic [1:0] {CAL, RUN_IDLE, RUN_SWEEP} gyro_state_e;

  // Add two sign-extended operands and clamp to a signed 'width'-bit range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned width);
    logic signed [63:0] sum, hi, lo;
    sum = a + b;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/gyro_tick_gen.sv
// Free-running sample-rate divider: tick is high when the count sits at DIV-1.
module gyro_tick_gen #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] count;

  assign tick = (count == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (clr || tick) count <= '0;
    else             count <= count + CW'(1);
  end

endmodule

// File: rtl/gyro_integrator.sv
// N-channel gyro rate integrator: bias calibration, one shared saturating adder
// swept across channels after each sample tick, and saturated angle outputs.
module gyro_integrator
  import gyro_pkg::*;
#(
  parameter int CHANNELS   = 3,
  parameter int IN_WIDTH   = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_BITS  = 8,
  parameter int SAMPLE_DIV = 100000,
  parameter int CAL_LOG2   = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [CHANNELS*IN_WIDTH-1:0]  rate_in,
  input  logic                          cal_start_in,
  input  logic                          zero_in,
  output logic [CHANNELS*OUT_WIDTH-1:0] angle_out,
  output logic                          valid_out,
  output logic                          cal_busy_out
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BS_W = IN_WIDTH + CAL_LOG2;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  gyro_state_e                  state;
  logic                         tick;
  logic [CH_W-1:0]              ch;
  logic [CAL_LOG2-1:0]          cal_cnt;
  logic signed [IN_WIDTH-1:0]   rate     [CHANNELS];
  logic signed [IN_WIDTH-1:0]   snap     [CHANNELS];
  logic signed [IN_WIDTH-1:0]   bias     [CHANNELS];
  logic signed [IN_WIDTH-1:0]   bias_new [CHANNELS];
  logic signed [BS_W-1:0]       bias_sum [CHANNELS];
  logic signed [BS_W-1:0]       bias_sum_nxt [CHANNELS];
  logic signed [ACC_WIDTH-1:0]  acc      [CHANNELS];
  logic signed [OUT_WIDTH-1:0]  angle    [CHANNELS];
  logic signed [IN_WIDTH:0]     diff;
  logic signed [ACC_WIDTH-1:0]  acc_nxt;
  logic signed [OUT_WIDTH-1:0]  angle_nxt;

  gyro_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
    .clk  (clk_in),
    .clr  (rst_in),
    .tick (tick)
  );

  // The final calibration tick folds its own sample in while loading the bias,
  // so the new bias is visible the cycle right after that tick.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign rate[c]         = rate_in[c*IN_WIDTH +: IN_WIDTH];
    assign angle_out[c*OUT_WIDTH +: OUT_WIDTH] = angle[c];
    assign bias_sum_nxt[c] = bias_sum[c] + BS_W'(rate[c]);
    assign bias_new[c]     = IN_WIDTH'(bias_sum_nxt[c] >>> CAL_LOG2);
  end

  always_comb begin
    diff      = (IN_WIDTH+1)'(snap[ch]) - (IN_WIDTH+1)'(bias[ch]);
    acc_nxt   = ACC_WIDTH'(sat_add(64'(acc[ch]), 64'(diff), ACC_WIDTH));
    angle_nxt = OUT_WIDTH'(sat_add(64'(acc_nxt >>> FRAC_BITS), 64'sd0, OUT_WIDTH));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= CAL;
      ch           <= '0;
      cal_cnt      <= '0;
      valid_out    <= 1'b0;
      cal_busy_out <= 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
        acc[c]      <= '0;
        bias[c]     <= '0;
        bias_sum[c] <= '0;
        snap[c]     <= '0;
        angle[c]    <= '0;
      end
    end else begin
      valid_out <= 1'b0;
      if (cal_start_in) begin
        // Old bias stays in place until the new calibration completes.
        state        <= CAL;
        ch           <= '0;
        cal_cnt      <= '0;
        cal_busy_out <= 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
          bias_sum[c] <= '0;
          acc[c]      <= '0;
          angle[c]    <= '0;
        end
      end else begin
        case (state)
          CAL: begin
            if (tick) begin
              cal_cnt <= cal_cnt + CAL_LOG2'(1);
              if (cal_cnt == '1) begin
                state        <= RUN_IDLE;
                cal_busy_out <= 1'b0;
                for (int c = 0; c < CHANNELS; c++) begin
                  bias[c]     <= bias_new[c];
                  bias_sum[c] <= '0;
                  acc[c]      <= '0;
                  angle[c]    <= '0;
                end
              end else begin
                for (int c = 0; c < CHANNELS; c++) bias_sum[c] <= bias_sum_nxt[c];
              end
            end
          end
          RUN_IDLE: begin
            if (zero_in) begin
              for (int c = 0; c < CHANNELS; c++) begin
                acc[c]   <= '0;
                angle[c] <= '0;
              end
            end else if (tick) begin
              for (int c = 0; c < CHANNELS; c++) snap[c] <= rate[c];
              ch    <= '0;
              state <= RUN_SWEEP;
            end
          end
          RUN_SWEEP: begin
            if (zero_in) begin
              state <= RUN_IDLE;
              for (int c = 0; c < CHANNELS; c++) begin
                acc[c]   <= '0;
                angle[c] <= '0;
              end
            end else begin
              acc[ch]   <= acc_nxt;
              angle[ch] <= angle_nxt;
              if (ch == LAST_CH) begin
                valid_out <= 1'b1;
                state     <= RUN_IDLE;
              end else begin
                ch <= ch + CH_W'(1);
              end
            end
          end
          default: state <= CAL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gyro_integrator.sv
// Directed bench for gyro_integrator: a main instance plus a narrow-accumulator
// instance used for the saturation scenario, sharing all inputs.
module tb_gyro_integrator;

  localparam int CH = 3;
  localparam int IW = 16;
  localparam int OW = 16;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              cal_start_in = 1'b0;
  logic              zero_in = 1'b0;
  logic [CH*IW-1:0]  rate_in = '0;
  logic [CH*OW-1:0]  angle_out, sat_angle;
  logic              valid_out, cal_busy_out, sat_valid, sat_busy;
  int                errors = 0;
  int                checks = 0;
  int                edge_n = 0;

  always #5 clk_in = ~clk_in;

  gyro_integrator #(.CHANNELS(CH), .IN_WIDTH(IW), .ACC_WIDTH(24), .OUT_WIDTH(OW),
                    .FRAC_BITS(4), .SAMPLE_DIV(8), .CAL_LOG2(2)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .rate_in(rate_in), .cal_start_in(cal_start_in),
    .zero_in(zero_in), .angle_out(angle_out), .valid_out(valid_out),
    .cal_busy_out(cal_busy_out));

  gyro_integrator #(.CHANNELS(CH), .IN_WIDTH(IW), .ACC_WIDTH(20), .OUT_WIDTH(OW),
                    .FRAC_BITS(0), .SAMPLE_DIV(8), .CAL_LOG2(2)) u_sat (
    .clk_in(clk_in), .rst_in(rst_in), .rate_in(rate_in), .cal_start_in(cal_start_in),
    .zero_in(zero_in), .angle_out(sat_angle), .valid_out(sat_valid),
    .cal_busy_out(sat_busy));

  // Edge n is the n-th rising edge after the initial reset; samples land 1 ns later.
  task automatic step_to(input int e);
    while (edge_n < e) begin
      @(posedge clk_in);
      #1;
      edge_n++;
    end
  endtask

  task automatic set_rates(input int r0, input int r1, input int r2);
    rate_in = {16'(r2), 16'(r1), 16'(r0)};
  endtask

  function automatic logic signed [OW-1:0] ang(input logic [CH*OW-1:0] v, input int c);
    return v[c*OW +: OW];
  endfunction

  task automatic test_reset;
    rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    checks++; if (angle_out !== '0) begin errors++; $display("FAIL reset_angle got %h want 0", angle_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_out); end
    checks++; if (cal_busy_out !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", cal_busy_out); end
  endtask

  task automatic test_calibration;
    set_rates(10, -6, 0);
    rst_in = 1'b0;
    step_to(11);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL cal_no_valid got %b want 0", valid_out); end
    step_to(31);
    checks++; if (cal_busy_out !== 1'b1) begin errors++; $display("FAIL cal_busy_hold got %b want 1", cal_busy_out); end
    step_to(32);
    checks++; if (cal_busy_out !== 1'b0) begin errors++; $display("FAIL cal_busy_fall got %b want 0", cal_busy_out); end
    step_to(42);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL run_valid_early got %b want 0", valid_out); end
    step_to(43);
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL run_valid_pulse got %b want 1", valid_out); end
    checks++; if (angle_out !== '0) begin errors++; $display("FAIL run_bias_angles got %h want 0", angle_out); end
    step_to(44);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL run_valid_width got %b want 0", valid_out); end
    step_to(51);
    checks++; if (valid_out !== 1'b1 || angle_out !== '0) begin
      errors++; $display("FAIL run_period got valid=%b angle=%h want valid=1 angle=0", valid_out, angle_out);
    end
  endtask

  task automatic test_cal_zero;
    set_rates(26, -6, 0);
    step_to(59);
    checks++; if (valid_out !== 1'b1 || ang(angle_out, 0) !== 16'(1)) begin
      errors++; $display("FAIL pre_cal_angle0 got valid=%b angle0=%0d want 1/1", valid_out, ang(angle_out, 0));
    end
    step_to(60);
    set_rates(0, 0, 0);
    cal_start_in = 1'b1;
    zero_in = 1'b1;
    step_to(61);
    cal_start_in = 1'b0;
    zero_in = 1'b0;
    checks++; if (cal_busy_out !== 1'b1) begin errors++; $display("FAIL recal_busy got %b want 1", cal_busy_out); end
    checks++; if (angle_out !== '0) begin errors++; $display("FAIL recal_angles got %h want 0", angle_out); end
    step_to(67);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL recal_no_valid got %b want 0", valid_out); end
    step_to(87);
    checks++; if (cal_busy_out !== 1'b1) begin errors++; $display("FAIL recal_busy_hold got %b want 1", cal_busy_out); end
    step_to(88);
    checks++; if (cal_busy_out !== 1'b0) begin errors++; $display("FAIL recal_busy_fall got %b want 0", cal_busy_out); end
  endtask

  task automatic test_integrate;
    set_rates(16, 0, 0);
    step_to(99);
    checks++; if (ang(angle_out, 0) !== 16'(1)) begin errors++; $display("FAIL integ_first got %0d want 1", ang(angle_out, 0)); end
    step_to(131);
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL integ_valid got %b want 1", valid_out); end
    checks++; if (ang(angle_out, 0) !== 16'(5)) begin errors++; $display("FAIL integ_ch0 got %0d want 5", ang(angle_out, 0)); end
    checks++; if (ang(angle_out, 1) !== 16'(0) || ang(angle_out, 2) !== 16'(0)) begin
      errors++; $display("FAIL integ_others got %0d,%0d want 0,0", ang(angle_out, 1), ang(angle_out, 2));
    end
    set_rates(0, -32, 0);
    step_to(147);
    checks++; if (ang(angle_out, 1) !== 16'(-4)) begin errors++; $display("FAIL integ_ch1 got %0d want -4", ang(angle_out, 1)); end
    checks++; if (ang(angle_out, 0) !== 16'(5)) begin errors++; $display("FAIL integ_ch0_hold got %0d want 5", ang(angle_out, 0)); end
  endtask

  task automatic test_saturation;
    set_rates(0, 0, 32767);
    step_to(155);
    checks++; if (ang(sat_angle, 2) !== 16'(32767)) begin errors++; $display("FAIL sat_first got %0d want 32767", ang(sat_angle, 2)); end
    step_to(307);
    checks++; if (ang(sat_angle, 2) !== 16'(32767)) begin errors++; $display("FAIL sat_hold_pos got %0d want 32767", ang(sat_angle, 2)); end
    checks++; if (ang(angle_out, 2) !== 16'(32767)) begin errors++; $display("FAIL sat_out_pos got %0d want 32767", ang(angle_out, 2)); end
    set_rates(0, 0, -32768);
    step_to(435);
    checks++; if (ang(sat_angle, 2) !== 16'(-1)) begin errors++; $display("FAIL sat_acc_clamped got %0d want -1", ang(sat_angle, 2)); end
    checks++; if (ang(angle_out, 2) !== 16'(8190)) begin errors++; $display("FAIL sat_wide_acc got %0d want 8190", ang(angle_out, 2)); end
    step_to(443);
    checks++; if (ang(sat_angle, 2) !== 16'(-32768)) begin errors++; $display("FAIL sat_neg_first got %0d want -32768", ang(sat_angle, 2)); end
    step_to(627);
    checks++; if (ang(sat_angle, 2) !== 16'(-32768)) begin errors++; $display("FAIL sat_hold_neg got %0d want -32768", ang(sat_angle, 2)); end
    checks++; if (ang(angle_out, 2) !== 16'(-32768)) begin errors++; $display("FAIL sat_out_neg got %0d want -32768", ang(angle_out, 2)); end
    set_rates(0, 0, 0);
  endtask

  task automatic test_zero;
    step_to(632);
    zero_in = 1'b1;
    step_to(633);
    zero_in = 1'b0;
    set_rates(16, 0, 0);
    checks++; if (angle_out !== '0) begin errors++; $display("FAIL zero_angles got %h want 0", angle_out); end
    step_to(635);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL zero_abort_valid got %b want 0", valid_out); end
    step_to(643);
    checks++; if (valid_out !== 1'b1 || ang(angle_out, 0) !== 16'(1)) begin
      errors++; $display("FAIL zero_resume got valid=%b angle0=%0d want 1/1", valid_out, ang(angle_out, 0));
    end
    checks++; if (ang(angle_out, 2) !== 16'(0)) begin errors++; $display("FAIL zero_ch2 got %0d want 0", ang(angle_out, 2)); end
  endtask

  task automatic test_reset_mid_cal;
    step_to(644);
    set_rates(100, 100, 100);
    cal_start_in = 1'b1;
    step_to(645);
    cal_start_in = 1'b0;
    step_to(655);
    rst_in = 1'b1;
    step_to(656);
    checks++; if (angle_out !== '0 || valid_out !== 1'b0 || cal_busy_out !== 1'b1) begin
      errors++; $display("FAIL midcal_reset got angle=%h valid=%b busy=%b want 0/0/1", angle_out, valid_out, cal_busy_out);
    end
    rst_in = 1'b0;
    set_rates(5, 5, 5);
    step_to(687);
    checks++; if (cal_busy_out !== 1'b1) begin errors++; $display("FAIL midcal_busy_hold got %b want 1", cal_busy_out); end
    step_to(688);
    checks++; if (cal_busy_out !== 1'b0) begin errors++; $display("FAIL midcal_busy_fall got %b want 0", cal_busy_out); end
    set_rates(21, 5, 5);
    step_to(699);
    checks++; if (valid_out !== 1'b1 || ang(angle_out, 0) !== 16'(1)) begin
      errors++; $display("FAIL midcal_bias got valid=%b angle0=%0d want 1/1", valid_out, ang(angle_out, 0));
    end
    checks++; if (ang(angle_out, 1) !== 16'(0)) begin errors++; $display("FAIL midcal_ch1 got %0d want 0", ang(angle_out, 1)); end
  endtask

  initial begin
    test_reset;
    test_calibration;
    test_cal_zero;
    test_integrate;
    test_saturation;
    test_zero;
    test_reset_mid_cal;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gyro_integrator.md
# gyro_integrator

Parametrised successor to the single-purpose gyro post-processing stage: integrates N signed angular-rate channels into saturating angle estimates at a programmable sample rate. Includes bias calibration at reset and on request, and a zero command. It sits between the MPU rate registers and the renderer/debug taps, in the 100 MHz domain. Channels are updated serially through one shared adder, so the sweep takes one cycle per channel.

## Interface
- CHANNELS, 3: number of rate/angle channels
- IN_WIDTH, 16: signed rate sample width
- ACC_WIDTH, 32: signed accumulator width; must be > IN_WIDTH+1
- OUT_WIDTH, 16: signed angle output width
- FRAC_BITS, 8: accumulator LSBs dropped to form the angle
- SAMPLE_DIV, 100000: clk_in cycles per sample tick; must be ≥ CHANNELS+2
- CAL_LOG2, 8: calibration length is 2^CAL_LOG2 ticks
- clk_in  input  1  system clock (100 MHz)
- rst_in  input  1  synchronous, active-high reset
- rate_in  input  CHANNELS*IN_WIDTH  packed signed rates; channel c is at [c*IN_WIDTH +: IN_WIDTH]
- cal_start_in  input  1  one-cycle request to recalibrate
- zero_in  input  1  one-cycle request to clear all angles
- angle_out  output  CHANNELS*OUT_WIDTH  packed signed angles, same packing as rate_in
- valid_out  output  1  one-cycle pulse when angle_out has been updated
- cal_busy_out  output  1  high while calibration is in progress

## Operation
- Tick counter free-runs 0..SAMPLE_DIV-1. tick is asserted when count == SAMPLE_DIV-1, then the counter wraps to 0.
- On tick, all rate_in channels are snapshotted into a holding register. Channels are then processed c=0..CHANNELS-1, one per cycle.
- FSM states:
  - CAL: each tick adds the sign-extended rate to bias_sum[c]. After 2^CAL_LOG2 ticks, bias[c] = bias_sum[c] >>> CAL_LOG2 (arithmetic), and acc and bias_sum are cleared. The FSM then goes to RUN. No valid_out is produced in CAL.
  - RUN_IDLE: wait for tick, then go to RUN_SWEEP.
  - RUN_SWEEP: acc[c] ← sat_ACC(acc[c] + (rate[c] − bias[c])), with all operands sign-extended to ACC_WIDTH+1 bits. After the last channel, pulse valid_out and return to RUN_IDLE.
- Angle: angle[c] = sat_OUT(acc[c] >>> FRAC_BITS), registered. Saturation clamps to the signed min/max of the target width; it never wraps.
- cal_start_in in any state:
  - enter CAL and clear bias_sum, the cal tick count and acc.
  - keep the old bias until the new calibration completes.
  - angle_out goes to 0.
- zero_in in RUN_IDLE or RUN_SWEEP: clear all acc and angle_out. An in-progress sweep is aborted with no valid_out. zero_in is ignored in CAL.
- Simultaneous events:
  - cal_start_in with zero_in: cal_start_in wins.
  - zero_in with tick: the tick is discarded.
  - cal_start_in with tick: the tick is discarded and calibration starts counting at the next tick.

## Timing
- Reset values:
  - angle_out = 0, valid_out = 0, cal_busy_out = 1
  - bias = 0, acc = 0, tick count = 0
  - state = CAL, i.e. auto-calibration runs after reset.
- Latency:
  - channel c's acc updates in cycle tick+1+c.
  - valid_out is high in cycle tick+CHANNELS+1, and angle_out is valid in that same cycle.
- valid_out is high for exactly one cycle per RUN tick, and is never high while cal_busy_out = 1.
- cal_busy_out:
  - rises the cycle after cal_start_in.
  - falls the cycle after the final calibration tick, in the same cycle the new bias becomes visible.
- rst_in mid-sweep or mid-calibration forces all reset values on the next edge.

## Structure
- gyro_pkg holds:
  - the FSM state typedef {CAL, RUN_IDLE, RUN_SWEEP}
  - the saturating-add function, parametrised through width arguments.
- One sub-module, gyro_tick_gen: the SAMPLE_DIV counter with a tick output and a synchronous clear. It is reused by other sensor blocks.
- Per-channel storage (acc, bias, bias_sum, snapshot) uses unpacked arrays indexed by a channel counter of width $clog2(CHANNELS).

## Test plan
Bench parameters: CHANNELS=3, SAMPLE_DIV=8, CAL_LOG2=2, FRAC_BITS=4, ACC_WIDTH=24, OUT_WIDTH=16.
- Reset, then hold rates (10, −6, 0) → after 4 ticks bias = (10, −6, 0) and cal_busy_out falls. With rates held, angles stay 0 and valid_out pulses every 8 cycles, 4 cycles after each tick.
- Bias 0, ch0 = 16 for 5 ticks → acc0 = 80, angle0 = 5. Channels 1 and 2 stay 0. ch1 = −32 for 2 ticks → angle1 = −4.
- ACC_WIDTH=20, FRAC_BITS=0, OUT_WIDTH=16, ch2 = 32767 repeatedly → angle2 clamps at 32767 and holds. ch2 = −32768 repeatedly → angle2 clamps at −32768.
- zero_in one cycle after a tick → no valid_out for that tick. All angles read 0 the next cycle, and the next tick resumes integrating from 0.
- In RUN, cal_start_in together with zero_in → cal_busy_out = 1 next cycle and angles = 0. The old bias is used until 4 ticks later, when the new bias loads.
- rst_in asserted during the 2nd calibration tick → all outputs return to reset values and calibration restarts, requiring 4 full ticks.
